vbw_seq_mul: RTL

//  Iterative shift-and-add lane-partitioned multiplier sitting directly upstream of the vbw adders.

---
 rtl/vbw_seq_mul.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vbw_seq_mul.sv
// vbw_seq_mul: iterative shift-and-add multiplier with lanes.
// The 64-bit datapath splits into 1x64, 2x32, 4x16 or 8x8 lanes.
// Every busy cycle does one lane-isolated add. Carries never cross a lane boundary.
// Each lane returns (a_lane * b_lane) mod 2^L.
// The job runs for a fixed L cycles, even when an operand is zero.
module vbw_seq_mul #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] p,
    output logic             busy
);

    // The lane map is built from byte slices. The narrowest lane is one byte.
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mc_q, mc_d;     // multiplicand, shifts left inside each lane
    logic [WIDTH-1:0] mp_q, mp_d;     // multiplier, shifts right inside each lane
    logic [WIDTH-1:0] acc_q, acc_d;   // running partial products
    logic [WIDTH-1:0] p_q, p_d;       // finished result shown on p
    logic [1:0]       mode_q, mode_d; // lane mode latched when the job is accepted
    logic [CNT_W-1:0] cnt_q, cnt_d;   // iterations left, minus one

    // Lane geometry, derived from the latched mode.
    logic [2:0]        lane_mask;     // byte-index bits that vary within one lane
    logic [NBYTES-1:0] lane_start;    // byte holds the LSB of its lane
    logic [NBYTES-1:0] lane_end;      // byte holds the MSB of its lane
    logic [NBYTES-1:0] add_en;        // this byte's lane adds mc on this cycle
    logic [WIDTH-1:0]  msb_mask;      // one bit set at each lane MSB
    logic [WIDTH-1:0]  lsb_mask;      // one bit set at each lane LSB
    logic [WIDTH-1:0]  addend_w;      // mc, gated per lane by the multiplier LSB
    logic [WIDTH-1:0]  sum_w;         // acc + addend, carries cut at lane boundaries
    logic [WIDTH-1:0]  shl_w;         // mc shifted left by one inside each lane
    logic [WIDTH-1:0]  shr_w;         // mp shifted right by one inside each lane
    logic [CNT_W-1:0]  first_cnt;     // L-1 for the mode being accepted

    // Map the latched mode to the byte-index bits shared by one lane.
    always_comb begin
        lane_mask = 3'd0;
        case (mode_q)
            2'b00:   lane_mask = 3'd7;
            2'b01:   lane_mask = 3'd3;
            2'b10:   lane_mask = 3'd1;
            default: lane_mask = 3'd0;
        endcase
    end

    // Map the incoming control to the starting iteration count, L-1.
    always_comb begin
        first_cnt = CNT_W'(7);
        case (control)
            2'b00:   first_cnt = CNT_W'(63);
            2'b01:   first_cnt = CNT_W'(31);
            2'b10:   first_cnt = CNT_W'(15);
            default: first_cnt = CNT_W'(7);
        endcase
    end

    // Per-byte lane masks, gated addend and multiplier-LSB selection.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_byte
        localparam logic [2:0] BI = 3'(gi);
        // Index of the first byte of the lane that contains this byte.
        logic [2:0] base_byte;

        assign base_byte      = BI & ~lane_mask;
        assign lane_start[gi] = ((BI & lane_mask) == 3'd0);
        assign lane_end[gi]   = ((BI & lane_mask) == lane_mask);
        assign add_en[gi]     = mp_q[{base_byte, 3'b000}];

        assign msb_mask[8*gi +: 8] = {lane_end[gi], 7'd0};
        assign lsb_mask[8*gi +: 8] = {7'd0, lane_start[gi]};
        assign addend_w[8*gi +: 8] = add_en[gi] ? mc_q[8*gi +: 8] : 8'd0;
    end

    // Lane-isolated add.
    // Clearing each lane MSB before the full-width add means no carry can leave a lane.
    // The MSB is then rebuilt as a ^ b ^ carry-in, and that lane's carry-out is dropped.
    always_comb begin
        sum_w = ((acc_q & ~msb_mask) + (addend_w & ~msb_mask))
              ^ ((acc_q ^ addend_w) & msb_mask);
    end

    // Lane-local shifts.
    // A bit that crosses a lane boundary is dropped, and zero fills in from the lane edge.
    always_comb begin
        shl_w = (mc_q << 1) & ~lsb_mask;
        shr_w = (mp_q >> 1) & ~msb_mask;
    end

    // Next-state logic, datapath updates and handshake outputs for the FSM.
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        acc_d     = acc_q;
        p_d       = p_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mc_d    = a;
                    mp_d    = b;
                    mode_d  = control;
                    acc_d   = '0;
                    cnt_d   = first_cnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                busy  = 1'b1;
                acc_d = sum_w;
                mc_d  = shl_w;
                mp_d  = shr_w;
                if (cnt_q == '0) begin
                    // Latch the result so p stays stable for as long as DONE lasts.
                    p_d     = sum_w;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // The asynchronous reset drops any job in flight and clears p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mc_q    <= '0;
            mp_q    <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign p = p_q;

endmodule
